// File: rtl/inst_pos_arbiter_pkg.sv
// rtl/inst_pos_arbiter_pkg.sv - shared types and widths for the instruction-memory arbiter
package inst_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

endpackage

// File: rtl/inst_pos_arbiter_if.sv
// rtl/inst_pos_arbiter_if.sv - requester and memory channel bundle of the instruction-memory arbiter
interface inst_pos_arbiter_if
  import inst_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]             req_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]             ack_o;
  logic [NUM_REQ-1:0]             error_o;
  logic [DATA_W-1:0]              data_o;
  logic                           mem_req_o;
  logic [ADDR_W-1:0]              mem_addr_o;
  logic                           mem_ack_i;
  logic                           mem_error_i;
  logic [DATA_W-1:0]              mem_data_i;

  modport slave (
    input  req_i, addr_i, mem_ack_i, mem_error_i, mem_data_i,
    output ack_o, error_o, data_o, mem_req_o, mem_addr_o
  );

  modport master (
    output req_i, addr_i, mem_ack_i, mem_error_i, mem_data_i,
    input  ack_o, error_o, data_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/inst_pos_arbiter_rr_pick.sv
// rtl/inst_pos_arbiter_rr_pick.sv - round-robin winner search starting just above the last grant
module inst_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // last_idx itself is visited last so the previous winner has lowest priority
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_idx) + off) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/inst_pos_arbiter.sv
// rtl/inst_pos_arbiter.sv - round-robin arbiter for the shared instruction memory, one transaction outstanding
// INST_ARB_TIMEOUT_EN adds a BUSY watchdog that forces an error response after TIMEOUT_CYC cycles.
module inst_pos_arbiter
  import inst_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               clk_i,
  input logic               rst_ni,
  inst_pos_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]          last_idx_q, last_idx_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d;
  logic [NUM_REQ-1:0]        error_q, error_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic                      mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic                      pick_valid;
  logic [IDX_W-1:0]          pick_idx;

`ifdef INST_ARB_TIMEOUT_EN
  localparam int TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  inst_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (bus.req_i),
    .last_idx (last_idx_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    ack_d      = '0;
    error_d    = '0;
    data_d     = data_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
`ifdef INST_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_idx_d  = pick_idx;
          last_idx_d = pick_idx;
          mem_addr_d = bus.addr_i[pick_idx];
          mem_req_d  = 1'b1;
          state_d    = BUSY;
`ifdef INST_ARB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      BUSY: begin
`ifdef INST_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        // a real memory ack always beats the watchdog in the same cycle
        if (bus.mem_ack_i) begin
          data_d             = bus.mem_data_i;
          ack_d[gnt_idx_q]   = 1'b1;
          error_d[gnt_idx_q] = bus.mem_error_i;
          mem_req_d          = 1'b0;
          state_d            = RESP;
        end
`ifdef INST_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          data_d             = '0;
          ack_d[gnt_idx_q]   = 1'b1;
          error_d[gnt_idx_q] = 1'b1;
          mem_req_d          = 1'b0;
          state_d            = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= IDX_W'(NUM_REQ - 1);
      ack_q      <= '0;
      error_q    <= '0;
      data_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
`ifdef INST_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      ack_q      <= ack_d;
      error_q    <= error_d;
      data_q     <= data_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
`ifdef INST_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.error_o    = error_q;
  assign bus.data_o     = data_q;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_inst_pos_arbiter.sv
// tb/tb_inst_pos_arbiter.sv - directed self-checking bench for inst_pos_arbiter
module tb_inst_pos_arbiter;

  logic clk_i;
  logic rst_ni;
  int   n_checks;
  int   n_fail;

  inst_pos_arbiter_if #(.NUM_REQ(2)) bus ();

  inst_pos_arbiter #(
    .NUM_REQ     (2),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // waits (bounded) for mem_req_o, returns at the negedge where it is first seen high
  task automatic wait_mem_req(input string tag, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (bus.mem_req_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_mem_req_timeout"}, 64'd0, 64'd1);
  endtask

  // serves one memory transaction acked at edge `lat` after the grant edge
  task automatic serve(input string tag, input int lat, input logic [31:0] data, input logic err,
                       input int exp_idx, input logic [31:0] exp_addr);
    bit seen;
    logic [1:0] exp_ack;
    wait_mem_req(tag, seen);
    if (!seen) return;
    exp_ack = 2'b01 << exp_idx;
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'(exp_addr));
    repeat (lat - 1) @(negedge clk_i);
    bus.mem_ack_i   = 1'b1;
    bus.mem_data_i  = data;
    bus.mem_error_i = err;
    @(negedge clk_i);
    bus.mem_ack_i   = 1'b0;
    bus.mem_error_i = 1'b0;
    chk({tag, "_ack"},     64'(bus.ack_o),     64'(exp_ack));
    chk({tag, "_error"},   64'(bus.error_o),   err ? 64'(exp_ack) : 64'd0);
    chk({tag, "_data"},    64'(bus.data_o),    64'(data));
    chk({tag, "_mem_req"}, 64'(bus.mem_req_o), 64'd0);
  endtask

  initial begin
    bit seen;
    n_checks        = 0;
    n_fail          = 0;
    rst_ni          = 1'b0;
    bus.req_i       = '0;
    bus.addr_i      = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_error_i = 1'b0;
    bus.mem_data_i  = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ack",      64'(bus.ack_o),      64'd0);
    chk("rst_error",    64'(bus.error_o),    64'd0);
    chk("rst_data",     64'(bus.data_o),     64'd0);
    chk("rst_mem_req",  64'(bus.mem_req_o),  64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    rst_ni = 1'b1;

    // single request, ack two cycles after the grant
    @(negedge clk_i);
    bus.addr_i[0] = 32'h0000_0100;
    bus.addr_i[1] = 32'h0000_0200;
    bus.req_i     = 2'b01;
    serve("single", 2, 32'hDEAD_BEEF, 1'b0, 0, 32'h0000_0100);
    bus.req_i = 2'b00;
    @(negedge clk_i);
    chk("single_ack_clear", 64'(bus.ack_o),  64'd0);
    chk("single_data_hold", 64'(bus.data_o), 64'hDEAD_BEEF);

    // stray memory ack while idle must be ignored
    repeat (2) @(negedge clk_i);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 32'h5555_5555;
    @(negedge clk_i);
    bus.mem_ack_i = 1'b0;
    chk("idle_ack_ignored", 64'(bus.ack_o),     64'd0);
    chk("idle_data_kept",   64'(bus.data_o),    64'hDEAD_BEEF);
    chk("idle_no_mem_req",  64'(bus.mem_req_o), 64'd0);

    // contention: both held high, alternating grants
    bus.addr_i[0] = 32'h0000_1000;
    bus.addr_i[1] = 32'h0000_2000;
    bus.req_i     = 2'b11;
    serve("rr0", 1, 32'hA000_0000, 1'b0, 1, 32'h0000_2000);
    serve("rr1", 3, 32'hA000_0001, 1'b0, 0, 32'h0000_1000);
    serve("rr2", 1, 32'hA000_0002, 1'b0, 1, 32'h0000_2000);
    serve("rr3", 2, 32'hA000_0003, 1'b0, 0, 32'h0000_1000);

    // error response to requester 1
    bus.req_i = 2'b10;
    serve("err", 2, 32'hBAD0_0001, 1'b1, 1, 32'h0000_2000);
    bus.req_i = 2'b00;

    // requester drops req mid-transaction, still acked
    @(negedge clk_i);
    bus.req_i = 2'b01;
    wait_mem_req("drop", seen);
    bus.req_i = 2'b00;
    @(negedge clk_i);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = 32'h0D0D_0D0D;
    @(negedge clk_i);
    bus.mem_ack_i = 1'b0;
    chk("drop_ack",  64'(bus.ack_o),  64'b01);
    chk("drop_data", 64'(bus.data_o), 64'h0D0D_0D0D);

`ifdef INST_ARB_TIMEOUT_EN
    // memory never acks: forced error at the fourth BUSY edge
    repeat (2) @(negedge clk_i);
    bus.req_i = 2'b01;
    wait_mem_req("tmo", seen);
    repeat (3) @(negedge clk_i);
    chk("tmo_pre_ack",     64'(bus.ack_o),     64'd0);
    chk("tmo_pre_mem_req", 64'(bus.mem_req_o), 64'd1);
    @(negedge clk_i);
    chk("tmo_ack",     64'(bus.ack_o),     64'b01);
    chk("tmo_error",   64'(bus.error_o),   64'b01);
    chk("tmo_data",    64'(bus.data_o),    64'd0);
    chk("tmo_mem_req", 64'(bus.mem_req_o), 64'd0);
    bus.req_i = 2'b00;

    // ack lands in the timeout cycle: normal response wins
    repeat (2) @(negedge clk_i);
    bus.req_i = 2'b01;
    serve("tmo_race", 4, 32'h1234_5678, 1'b0, 0, 32'h0000_1000);
    bus.req_i = 2'b00;
`endif

    // reset during BUSY clears outputs without waiting for a clock
    repeat (2) @(negedge clk_i);
    bus.req_i = 2'b10;
    wait_mem_req("rstbusy", seen);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstbusy_mem_req",  64'(bus.mem_req_o),  64'd0);
    chk("rstbusy_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    chk("rstbusy_data",     64'(bus.data_o),     64'd0);
    chk("rstbusy_ack",      64'(bus.ack_o),      64'd0);
    bus.req_i = 2'b11;
    @(negedge clk_i);
    rst_ni = 1'b1;
    serve("post_rst", 1, 32'hCAFE_F00D, 1'b0, 0, 32'h0000_1000);
    bus.req_i = 2'b00;
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/inst_pos_arbiter.md
# inst_pos_arbiter

Round-robin arbiter that shares the posedge, multi-cycle instruction memory channel between `NUM_REQ` fetch requesters, for example the core's posedge fetch path and the boot/debug loader. It runs entirely in the `clk_i` domain and sits between the requesters and the slow instruction memory. It keeps exactly one transaction outstanding and returns data, ack and error only to the granted requester.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `TIMEOUT_CYC`, default 255: maximum BUSY cycles before a forced error response. Used only with the timeout feature.
- `clk_i` input 1: clock; all logic is posedge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_i` input `[NUM_REQ-1:0]`: per-requester request level. Hold high until the matching `ack_o` bit is seen.
- `addr_i` input `[NUM_REQ-1:0][31:0]`: per-requester fetch address. Must be stable while `req_i` is high.
- `ack_o` output `[NUM_REQ-1:0]`: one-cycle completion pulse, one-hot.
- `error_o` output `[NUM_REQ-1:0]`: error qualifier. Valid only together with `ack_o`.
- `data_o` output 32: shared read data. Valid when any `ack_o` bit is high.
- `mem_req_o` output 1: memory request level.
- `mem_addr_o` output 32: registered address of the granted requester.
- `mem_ack_i` input 1: memory completion pulse.
- `mem_error_i` input 1: memory error. Sampled with `mem_ack_i`.
- `mem_data_i` input 32: memory data. Sampled with `mem_ack_i`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - If any `req_i` bit is high: choose the winner round-robin, searching from `last_idx+1` upward with wrap-around.
  - Register the winner in `gnt_idx` and its address in `mem_addr_o`.
  - Set `mem_req_o` to 1, update `last_idx` to the winner, go to BUSY.
- BUSY
  - `mem_req_o` and `mem_addr_o` stay stable.
  - On `mem_ack_i`: register `data_o <= mem_data_i`, `ack_o[gnt_idx] <= 1`, `error_o[gnt_idx] <= mem_error_i`, `mem_req_o <= 0`, go to RESP.
- RESP
  - `ack_o`/`error_o` are high for exactly this cycle; they clear on the next edge.
  - Go to IDLE. No arbitration happens in RESP, so the served requester has one cycle to drop `req_i`.
- `data_o` holds its last value outside RESP. Only the `ack_o` bits are pulses.
- If a requester drops `req_i` during BUSY, the transaction still completes and is still acked (no abort).
- `mem_ack_i` seen in IDLE or RESP is ignored.
- Reset values: `ack_o`=0, `error_o`=0, `data_o`=0, `mem_req_o`=0, `mem_addr_o`=0, state=IDLE, `last_idx`=`NUM_REQ-1` (requester 0 wins first).
- Reset mid-transaction drops `mem_req_o` immediately (asynchronous). No response is issued.

## Timing
- Edge numbering: request first sampled at edge 0.
  - `mem_req_o` is high from edge 0.
  - For an ack at edge k (k ≥ 1), `ack_o` is high from edge k to edge k+1.
- Zero-wait memory (ack at edge 1): `ack_o` high in the cycle after edge 1. Next grant at edge 3.
- Throughput: one transaction per 3 cycles at best.
- All outputs are registered; no combinational path from `req_i` or `mem_*_i` to any output.

## Configuration
- `INST_ARB_TIMEOUT_EN`
  - Defined: an 8–16-bit counter clears on entry to BUSY and increments each BUSY cycle. When it reaches `TIMEOUT_CYC` without `mem_ack_i`, the block forces `ack_o[gnt_idx]`=1, `error_o[gnt_idx]`=1, `data_o`=0, `mem_req_o`=0, and goes to RESP.
  - If `mem_ack_i` arrives in the same cycle as the timeout, `mem_ack_i` wins: normal response, no forced error.
  - Undefined: no counter; BUSY waits indefinitely for `mem_ack_i`.

## Structure
- Package `inst_arb_pkg` holds:
  - the state typedef `arb_state_e` {IDLE, BUSY, RESP};
  - the `DATA_W`=32 and `ADDR_W`=32 constants.
- `IDX_W`=`$clog2(NUM_REQ)` is a local parameter of the arbiter.
- One combinational sub-module, `inst_rr_pick`: inputs `req` and `last_idx`; outputs `valid` and `idx`.

## Test plan
- Single request: `req_i`=01, `addr_i[0]`=0x0000_0100; memory acks 2 cycles later with data 0xDEAD_BEEF → `mem_addr_o`=0x100, `ack_o`=01 for one cycle, `data_o`=0xDEAD_BEEF, `error_o`=00.
- Contention: `req_i`=11 held continuously across 4 transactions → grant order 0,1,0,1; each `mem_addr_o` matches the granted requester's `addr_i`.
- Error: requester 1 is served and `mem_error_i`=1 arrives with the ack → `ack_o`=10 and `error_o`=10 in the same cycle.
- Timeout (macro on, `TIMEOUT_CYC`=4): memory never acks → at the timeout `ack_o`=01, `error_o`=01, `data_o`=0, `mem_req_o` drops. Repeat with `mem_ack_i` in the exact timeout cycle → normal ack, `error_o`=0.
- Reset mid-BUSY: assert `rst_ni`=0 while `mem_req_o`=1 → all outputs 0 immediately. After release, `req_i`=11 → requester 0 is granted first.
